// File: rtl/sram_controller.sv
// sram_controller
// Bridges the pipeline's 32-bit data-memory port to a 16-bit asynchronous
// SRAM. Each 32-bit load or store is split into two back-to-back halfword
// accesses, low half first, followed by WAIT_CYCLES padding states and a
// DONE state in which the pipeline is released.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   wr_en       store request from MEM stage (wins over rd_en)
//   rd_en       load request from MEM stage
//   address     byte address, word aligned
//   write_data  store data
//   read_data   registered load data, held until the next load
//   ready       combinational: low while a request is being serviced
//   SRAM_DQ     bidirectional SRAM data bus
//   SRAM_ADDR   SRAM halfword address
//   SRAM_UB_N / SRAM_LB_N / SRAM_CE_N   tied low
//   SRAM_WE_N   write strobe, active low
//   SRAM_OF_N   output enable, active low
module sram_controller #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_WE_N,
    output logic        SRAM_OF_N
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_WAIT,
        S_DONE
    } state_t;

    // Only eff[18:2] is used, so the subtraction is done modulo 2^19;
    // the low 19 bits match the full 32-bit difference.
    localparam logic [18:0] BASE_LOW  = BASE_ADDR[18:0];
    localparam logic [1:0]  WAIT_LOAD = (WAIT_CYCLES == 0) ? 2'd0 : 2'(WAIT_CYCLES - 1);

    state_t      state;
    logic        op_write;
    logic [16:0] word_idx;
    logic [15:0] wdata_hi;
    logic [15:0] dq_out;
    logic        dq_drive;
    logic [1:0]  wait_cnt;

    logic [18:0] eff;
    logic        unused_bits;

    assign eff         = address[18:0] - BASE_LOW;
    assign unused_bits = ^{address[31:19], eff[1:0]};

    assign SRAM_DQ   = dq_drive ? dq_out : 16'hzzzz;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;

    assign ready = ~(wr_en | rd_en) | (state == S_DONE);

    // Bus controls are registered alongside the state so that they change
    // on the same edge that enters LO / leaves HI.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            op_write  <= 1'b0;
            word_idx  <= '0;
            wdata_hi  <= '0;
            dq_out    <= '0;
            dq_drive  <= 1'b0;
            wait_cnt  <= '0;
            read_data <= '0;
            SRAM_ADDR <= '0;
            SRAM_WE_N <= 1'b1;
            SRAM_OF_N <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (wr_en | rd_en) begin
                        op_write  <= wr_en;
                        word_idx  <= eff[18:2];
                        wdata_hi  <= write_data[31:16];
                        SRAM_ADDR <= {eff[18:2], 1'b0};
                        state     <= S_LO;
                        if (wr_en) begin
                            SRAM_WE_N <= 1'b0;
                            dq_drive  <= 1'b1;
                            dq_out    <= write_data[15:0];
                        end else begin
                            SRAM_OF_N <= 1'b0;
                        end
                    end
                end
                S_LO: begin
                    if (!op_write) begin
                        read_data[15:0] <= SRAM_DQ;
                    end
                    dq_out    <= wdata_hi;
                    SRAM_ADDR <= {word_idx, 1'b1};
                    state     <= S_HI;
                end
                S_HI: begin
                    if (!op_write) begin
                        read_data[31:16] <= SRAM_DQ;
                    end
                    SRAM_WE_N <= 1'b1;
                    SRAM_OF_N <= 1'b1;
                    dq_drive  <= 1'b0;
                    wait_cnt  <= WAIT_LOAD;
                    state     <= (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Testbench for sram_controller: an asynchronous SRAM model on the bus, a
// driver issuing directed and random loads/stores, and a monitor that pops
// expected results from a scoreboard queue whenever the DUT releases ready.
module tb_sram_controller;

    localparam int unsigned BASE = 1024;
    localparam int unsigned WC   = 2;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_ub_n, sram_lb_n, sram_ce_n, sram_we_n, sram_of_n;

    sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(WC)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .SRAM_DQ    (sram_dq),
        .SRAM_ADDR  (sram_addr),
        .SRAM_UB_N  (sram_ub_n),
        .SRAM_LB_N  (sram_lb_n),
        .SRAM_CE_N  (sram_ce_n),
        .SRAM_WE_N  (sram_we_n),
        .SRAM_OF_N  (sram_of_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM environment model
    logic [15:0] sram_mem [0:262143];
    assign sram_dq = (!sram_of_n && sram_we_n) ? sram_mem[sram_addr] : 16'hzzzz;
    always @(posedge clk) begin
        if (!sram_we_n) sram_mem[sram_addr] <= sram_dq;
    end

    // Reference model: 32-bit words stored as halfword pairs
    logic [15:0] ref_mem [int unsigned];
    logic [31:0] last_read;

    typedef struct {
        bit          is_write;
        logic [31:0] exp_rd;
        int unsigned lo_idx;
        logic [15:0] lo_val;
        logic [15:0] hi_val;
        logic [31:0] addr;
    } exp_t;
    exp_t sb_q [$];

    int checks;
    int fails;
    bit mon_en;

    function automatic int unsigned hw_index(input logic [31:0] a);
        logic [31:0] eff;
        eff = a - BASE;
        return ((eff / 4) % 131072) * 2;
    endfunction

    function automatic logic [15:0] ref_rd(input int unsigned idx);
        if (ref_mem.exists(idx)) return ref_mem[idx];
        return 16'h0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: counts stall / strobe cycles per request and compares on release
    int stall_cnt, we_cnt, of_cnt;
    always @(negedge clk) begin
        exp_t e;
        if (!mon_en) begin
            stall_cnt = 0; we_cnt = 0; of_cnt = 0;
        end else if (wr_en | rd_en) begin
            if (!sram_we_n) we_cnt++;
            if (!sram_of_n) of_cnt++;
            if (!ready) begin
                stall_cnt++;
            end else if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("stall_cycles", stall_cnt, 3 + WC);
                chk("we_cycles", we_cnt, e.is_write ? 2 : 0);
                chk("of_cycles", of_cnt, e.is_write ? 0 : 2);
                chk("read_data", read_data, e.exp_rd);
                if (e.is_write) begin
                    chk("mem_lo", {16'h0, sram_mem[e.lo_idx]}, {16'h0, e.lo_val});
                    chk("mem_hi", {16'h0, sram_mem[e.lo_idx + 1]}, {16'h0, e.hi_val});
                end
                $display("txn %s addr=%h read_data=%h stall=%0d", e.is_write ? "WR" : "RD",
                         e.addr, read_data, stall_cnt);
                stall_cnt = 0; we_cnt = 0; of_cnt = 0;
            end
        end
    end

    // Driver: apply request after a rising edge, hold until ready, then drop it
    task automatic do_op(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        bit   got;
        e.is_write = w;
        e.lo_idx   = hw_index(a);
        e.lo_val   = d[15:0];
        e.hi_val   = d[31:16];
        e.addr     = a;
        if (w) begin
            ref_mem[e.lo_idx]     = d[15:0];
            ref_mem[e.lo_idx + 1] = d[31:16];
            e.exp_rd = last_read;
        end else begin
            e.exp_rd  = {ref_rd(e.lo_idx + 1), ref_rd(e.lo_idx)};
            last_read = e.exp_rd;
        end
        sb_q.push_back(e);
        wr_en = w; rd_en = r; address = a; write_data = d;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ready) got = 1'b1;
        end
        if (!got) begin
            checks++; fails++;
            $display("FAIL ready_timeout: got 0 expected 1 addr %h", a);
        end
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        bit          w;
        checks = 0; fails = 0; mon_en = 1'b0; last_read = 32'h0;
        for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0;
        wr_en = 0; rd_en = 0; address = 0; write_data = 0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_we_n", {31'h0, sram_we_n}, 32'd1);
        chk("rst_of_n", {31'h0, sram_of_n}, 32'd1);
        chk("rst_dq_z", {31'h0, (sram_dq === 16'hzzzz)}, 32'd1);
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_addr", {14'h0, sram_addr}, 32'h0);
        chk("rst_ready", {31'h0, ready}, 32'd1);
        chk("tie_n", {29'h0, sram_ce_n, sram_ub_n, sram_lb_n}, 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Directed sequence
        do_op(1, 0, 32'd1024, 32'h12345678);
        do_op(0, 1, 32'd1024, 32'h0);
        do_op(1, 0, 32'd1028, 32'hDEADBEEF);
        do_op(1, 1, 32'd1032, 32'hCAFEF00D);
        do_op(0, 1, 32'd1024, 32'h0);
        do_op(0, 1, 32'd1028, 32'h0);
        chk("sb_drained", sb_q.size(), 0);

        // Reset in cycle 2 (HI) of a store to 1036 (halfwords 6 and 7)
        mon_en = 1'b0;
        wr_en = 1'b1; address = 32'd1036; write_data = 32'hA5A55A5A;
        @(posedge clk);                 // -> LO
        @(posedge clk); #2;             // -> HI, then reset
        rst = 1'b0;
        #1;
        chk("midrst_we_n", {31'h0, sram_we_n}, 32'd1);
        chk("midrst_dq_z", {31'h0, (sram_dq === 16'hzzzz)}, 32'd1);
        wr_en = 1'b0;
        @(posedge clk); #1;
        chk("midrst_hi_unwritten", {16'h0, sram_mem[7]}, 32'h0);
        chk("midrst_lo_written", {16'h0, sram_mem[6]}, 32'h00005A5A);
        chk("midrst_read_data", read_data, 32'h0);
        ref_mem[6] = 16'h5A5A;
        last_read  = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        do_op(0, 1, 32'd1036, 32'h0);

        // Randomized traffic, including addresses below BASE that wrap
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) a = BASE - 4 * $urandom_range(1, 4);
            else                           a = BASE + 4 * $urandom_range(0, 31);
            w = $urandom_range(0, 1);
            do_op(w, w ? bit'($urandom_range(0, 1)) : 1'b1, a, $urandom);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (4) @(posedge clk);
        chk("sb_final_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
